// File: rtl/parking_lot_scheduler_pkg.sv
// Shared constants and the hour-to-capacity mapping for the parking lot scheduler.
package parking_pkg;

    localparam int   HOURS_PER_DAY = 24;
    localparam logic CLASS_FREE    = 1'b0;
    localparam logic CLASS_UNI     = 1'b1;

    // Free capacity holds at base before the ramp and at the ramp-end value after it.
    function automatic int free_capacity(input int hour, input int base, input int step,
                                         input int ramp_start, input int ramp_end);
        int h;
        h = hour;
        if (h < ramp_start) h = ramp_start;
        if (h > ramp_end)   h = ramp_end;
        return base + step * (h - ramp_start);
    endfunction

endpackage

// File: rtl/parking_lot_scheduler_if.sv
// Gate-sensor inputs and display/billing outputs of the parking lot scheduler.
interface parking_lot_scheduler_if #(
    parameter int CNT_W       = 10,
    parameter int QUEUE_DEPTH = 8
);
    localparam int QCNT_W = $clog2(QUEUE_DEPTH) + 1;

    logic              car_entered;
    logic              is_uni_car_entered;
    logic              car_exited;
    logic              is_uni_car_exited;
    logic [4:0]        hour;
    logic [CNT_W-1:0]  uni_parked_car;
    logic [CNT_W-1:0]  free_parked_car;
    logic [CNT_W-1:0]  uni_vacated_space;
    logic [CNT_W-1:0]  free_vacated_space;
    logic              uni_is_vacated_space;
    logic              free_is_vacated_space;
    logic [QCNT_W-1:0] queue_count;
    logic              queue_admit;
    logic              ja_nist;
    logic              faulty_exit;

    modport master (
        output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
        input  hour, uni_parked_car, free_parked_car, uni_vacated_space, free_vacated_space,
        input  uni_is_vacated_space, free_is_vacated_space, queue_count, queue_admit,
        input  ja_nist, faulty_exit
    );

    modport slave (
        input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
        output hour, uni_parked_car, free_parked_car, uni_vacated_space, free_vacated_space,
        output uni_is_vacated_space, free_is_vacated_space, queue_count, queue_admit,
        output ja_nist, faulty_exit
    );

endinterface

// File: rtl/parking_lot_scheduler_fifo.sv
// One-bit waiting queue of car classes; push and pop may happen in the same cycle.
module parking_wait_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    din,
    output logic                    head,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/parking_lot_scheduler.sv
// Occupancy controller: hour clock, per-class counters with time-varying capacity,
// and an in-order waiting queue for cars that arrive while their class is full.
module parking_lot_scheduler
    import parking_pkg::*;
#(
    parameter int TOTAL_CAP     = 700,
    parameter int FREE_BASE     = 200,
    parameter int FREE_STEP     = 50,
    parameter int RAMP_START    = 13,
    parameter int RAMP_END      = 16,
    parameter int START_HOUR    = 8,
    parameter int CLKS_PER_HOUR = 500,
    parameter int QUEUE_DEPTH   = 8,
    parameter int CNT_W         = 10
) (
    input  logic                    clock,
    input  logic                    reset,
    parking_lot_scheduler_if.slave  bus
);
    localparam int TICK_W = $clog2(CLKS_PER_HOUR);
    localparam int QCNT_W = $clog2(QUEUE_DEPTH) + 1;

    logic [TICK_W-1:0] tick;
    logic [4:0]        hour_q;
    logic [CNT_W-1:0]  uni_cnt, free_cnt;
    logic [CNT_W-1:0]  uni_n, free_n;
    logic [CNT_W-1:0]  uni_cap, free_cap;
    logic              admit_q, ja_q, fault_q;
    logic              admit_n, ja_n, fault_n;

    logic              fifo_push, fifo_pop, fifo_head, fifo_full, fifo_empty;
    logic [QCNT_W-1:0] fifo_count;

    parking_wait_fifo #(.DEPTH(QUEUE_DEPTH)) u_wait_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (bus.is_uni_car_entered),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign free_cap = CNT_W'(free_capacity(int'(hour_q), FREE_BASE, FREE_STEP, RAMP_START, RAMP_END));
    assign uni_cap  = CNT_W'(TOTAL_CAP) - free_cap;

    // Exit, then queue-head admission, then the new arrival, all against this cycle's counts.
    always_comb begin
        uni_n     = uni_cnt;
        free_n    = free_cnt;
        fault_n   = 1'b0;
        admit_n   = 1'b0;
        ja_n      = 1'b0;
        fifo_pop  = 1'b0;
        fifo_push = 1'b0;

        if (bus.car_exited) begin
            if (bus.is_uni_car_exited == CLASS_UNI) begin
                if (uni_cnt == '0) fault_n = 1'b1;
                else               uni_n   = uni_cnt - CNT_W'(1);
            end else begin
                if (free_cnt == '0) fault_n = 1'b1;
                else                free_n  = free_cnt - CNT_W'(1);
            end
        end

        if (!fifo_empty) begin
            if (fifo_head == CLASS_UNI && uni_n < uni_cap) begin
                uni_n    = uni_n + CNT_W'(1);
                fifo_pop = 1'b1;
                admit_n  = 1'b1;
            end else if (fifo_head == CLASS_FREE && free_n < free_cap) begin
                free_n   = free_n + CNT_W'(1);
                fifo_pop = 1'b1;
                admit_n  = 1'b1;
            end
        end

        // Arrivals only bypass the queue when nobody is waiting.
        if (bus.car_entered) begin
            if (fifo_empty && bus.is_uni_car_entered == CLASS_UNI && uni_n < uni_cap)
                uni_n = uni_n + CNT_W'(1);
            else if (fifo_empty && bus.is_uni_car_entered == CLASS_FREE && free_n < free_cap)
                free_n = free_n + CNT_W'(1);
            else if (!fifo_full || fifo_pop)
                fifo_push = 1'b1;
            else
                ja_n = 1'b1;
        end
    end

    // Hour tick is a down-counter; reaching zero marks the end of the hour.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick     <= TICK_W'(CLKS_PER_HOUR - 1);
            hour_q   <= 5'(START_HOUR);
            uni_cnt  <= '0;
            free_cnt <= '0;
            admit_q  <= 1'b0;
            ja_q     <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            if (tick == '0) begin
                tick   <= TICK_W'(CLKS_PER_HOUR - 1);
                hour_q <= (hour_q == 5'(HOURS_PER_DAY - 1)) ? 5'd0 : hour_q + 5'd1;
            end else begin
                tick <= tick - TICK_W'(1);
            end
            uni_cnt  <= uni_n;
            free_cnt <= free_n;
            admit_q  <= admit_n;
            ja_q     <= ja_n;
            fault_q  <= fault_n;
        end
    end

    assign bus.hour                  = hour_q;
    assign bus.uni_parked_car        = uni_cnt;
    assign bus.free_parked_car       = free_cnt;
    assign bus.uni_vacated_space     = (uni_cnt >= uni_cap)   ? '0 : uni_cap - uni_cnt;
    assign bus.free_vacated_space    = (free_cnt >= free_cap) ? '0 : free_cap - free_cnt;
    assign bus.uni_is_vacated_space  = (uni_cnt < uni_cap);
    assign bus.free_is_vacated_space = (free_cnt < free_cap);
    assign bus.queue_count           = fifo_count;
    assign bus.queue_admit           = admit_q;
    assign bus.ja_nist               = ja_q;
    assign bus.faulty_exit           = fault_q;

endmodule

// File: tb/tb_parking_lot_scheduler.sv
// Randomized check of parking_lot_scheduler against a queue-based behavioural model.
module tb_parking_lot_scheduler;

    localparam int TOTAL_CAP  = 20;
    localparam int FREE_BASE  = 4;
    localparam int FREE_STEP  = 3;
    localparam int RAMP_START = 13;
    localparam int RAMP_END   = 16;
    localparam int START_HOUR = 11;
    localparam int CPH        = 60;
    localparam int QD         = 4;
    localparam int CNT_W      = 6;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    parking_lot_scheduler_if #(.CNT_W(CNT_W), .QUEUE_DEPTH(QD)) bus ();

    parking_lot_scheduler #(
        .TOTAL_CAP(TOTAL_CAP), .FREE_BASE(FREE_BASE), .FREE_STEP(FREE_STEP),
        .RAMP_START(RAMP_START), .RAMP_END(RAMP_END), .START_HOUR(START_HOUR),
        .CLKS_PER_HOUR(CPH), .QUEUE_DEPTH(QD), .CNT_W(CNT_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    int m_cyc = 0;
    int m_cnt [2] = '{0, 0};
    bit m_q [$];
    bit m_admit = 0, m_ja = 0, m_fault = 0;

    function automatic int m_hour();
        return (START_HOUR + m_cyc / CPH) % 24;
    endfunction

    function automatic int cap_of(bit cls, int hr);
        int h, fcap;
        h = (hr < RAMP_START) ? RAMP_START : (hr > RAMP_END) ? RAMP_END : hr;
        fcap = FREE_BASE + FREE_STEP * (h - RAMP_START);
        return cls ? TOTAL_CAP - fcap : fcap;
    endfunction

    initial forever begin
        @(posedge clock or posedge reset);
        if (reset) begin
            m_cyc = 0; m_cnt[0] = 0; m_cnt[1] = 0; m_q.delete();
            m_admit = 0; m_ja = 0; m_fault = 0;
        end else begin
            int hr;
            bit was_empty, cx, ce, hd;
            hr = m_hour();
            m_admit = 0; m_ja = 0; m_fault = 0;
            if (bus.car_exited) begin
                cx = bus.is_uni_car_exited;
                if (m_cnt[int'(cx)] == 0) m_fault = 1;
                else m_cnt[int'(cx)]--;
            end
            was_empty = (m_q.size() == 0);
            if (!was_empty) begin
                hd = m_q[0];
                if (m_cnt[int'(hd)] < cap_of(hd, hr)) begin
                    m_cnt[int'(hd)]++;
                    void'(m_q.pop_front());
                    m_admit = 1;
                end
            end
            if (bus.car_entered) begin
                ce = bus.is_uni_car_entered;
                if (was_empty && m_cnt[int'(ce)] < cap_of(ce, hr)) m_cnt[int'(ce)]++;
                else if (m_q.size() < QD) m_q.push_back(ce);
                else m_ja = 1;
            end
            m_cyc++;
        end
    end

    task automatic chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    initial forever begin
        @(negedge clock);
        if (!reset) begin
            int hr, uc, fc;
            hr = m_hour();
            uc = cap_of(1'b1, hr);
            fc = cap_of(1'b0, hr);
            chk("hour",       int'(bus.hour), hr);
            chk("uni_parked", int'(bus.uni_parked_car), m_cnt[1]);
            chk("free_parked", int'(bus.free_parked_car), m_cnt[0]);
            chk("uni_vac",    int'(bus.uni_vacated_space), (m_cnt[1] >= uc) ? 0 : uc - m_cnt[1]);
            chk("free_vac",   int'(bus.free_vacated_space), (m_cnt[0] >= fc) ? 0 : fc - m_cnt[0]);
            chk("uni_is_vac", int'(bus.uni_is_vacated_space), int'(m_cnt[1] < uc));
            chk("free_is_vac", int'(bus.free_is_vacated_space), int'(m_cnt[0] < fc));
            chk("queue_count", int'(bus.queue_count), m_q.size());
            chk("queue_admit", int'(bus.queue_admit), int'(m_admit));
            chk("ja_nist",    int'(bus.ja_nist), int'(m_ja));
            chk("faulty_exit", int'(bus.faulty_exit), int'(m_fault));
        end
    end

    // One cycle with the given inputs; returns just after the edge.
    task automatic cyc(bit e, bit ce, bit x, bit cx);
        bus.car_entered        = e;
        bus.is_uni_car_entered = ce;
        bus.car_exited         = x;
        bus.is_uni_car_exited  = cx;
        @(posedge clock); #1;
        bus.car_entered = 1'b0;
        bus.car_exited  = 1'b0;
    endtask

    initial begin
        bus.car_entered = 0; bus.is_uni_car_entered = 0;
        bus.car_exited = 0;  bus.is_uni_car_exited = 0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state: hour 11 -> free cap 4, uni cap 16.
        chk("rst_hour",     int'(bus.hour), 11);
        chk("rst_uni_vac",  int'(bus.uni_vacated_space), 16);
        chk("rst_free_vac", int'(bus.free_vacated_space), 4);
        chk("rst_queue",    int'(bus.queue_count), 0);

        // 9 free arrivals: 4 park, 4 queue, 1 rejected.
        for (int i = 0; i < 9; i++) cyc(1, 0, 0, 0);
        chk("fill_free_parked", int'(bus.free_parked_car), 4);
        chk("fill_queue",       int'(bus.queue_count), 4);
        chk("fill_ja_nist",     int'(bus.ja_nist), 1);
        chk("fill_free_vac",    int'(bus.free_vacated_space), 0);

        // Free exit: head admitted, count stays full.
        cyc(0, 0, 1, 0);
        chk("exit_admit",       int'(bus.queue_admit), 1);
        chk("exit_free_parked", int'(bus.free_parked_car), 4);
        chk("exit_queue",       int'(bus.queue_count), 3);

        // Uni arrival waits behind the free head despite uni space.
        cyc(1, 1, 0, 0);
        chk("hol_queue",      int'(bus.queue_count), 4);
        chk("hol_uni_parked", int'(bus.uni_parked_car), 0);

        // Uni exit with nothing parked.
        cyc(0, 0, 1, 1);
        chk("fault_pulse",  int'(bus.faulty_exit), 1);
        chk("fault_uni",    int'(bus.uni_parked_car), 0);
        cyc(0, 0, 0, 0);
        chk("fault_clear",  int'(bus.faulty_exit), 0);

        // Asynchronous reset with a full queue.
        #2 reset = 1'b1;
        #1;
        chk("arst_hour",  int'(bus.hour), 11);
        chk("arst_free",  int'(bus.free_parked_car), 0);
        chk("arst_queue", int'(bus.queue_count), 0);
        @(posedge clock); @(posedge clock); #1 reset = 1'b0;

        // Exit and entry at a full class in the same cycle.
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        chk("swap_free_parked", int'(bus.free_parked_car), 4);
        chk("swap_ja_nist",     int'(bus.ja_nist), 0);
        chk("swap_queue",       int'(bus.queue_count), 0);

        // Randomized traffic over more than a full day (covers ramp and wrap).
        for (int i = 0; i < 1600; i++)
            cyc($urandom_range(0, 99) < 50, 1'($urandom_range(0, 1)),
                $urandom_range(0, 99) < 25, 1'($urandom_range(0, 1)));

        @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
